// File: rtl/dram_banked_array.sv
// Byte-addressed single-port memory with a fixed acceptance-to-response latency.
// Optional DRAM_ALIGN_CHECK_EN rejects accesses whose address is not a multiple of the word size.
module dram_banked_array #(
  parameter int ADDR_W  = 10,
  parameter int WORD_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  wren,
  input  logic [ADDR_W-1:0]     address,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [WORD_W/8-1:0]   byte_en,
  output logic                  ready,
  output logic                  done,
  output logic [WORD_W-1:0]     rdata,
  output logic                  err
);

  localparam int NB    = WORD_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                wren_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   wdata_reg;
  logic [NB-1:0]       be_reg;
  logic                done_reg;
  logic [WORD_W-1:0]   rdata_reg;

  logic                accept;
  logic                commit;
  logic                misaligned;
  logic                wr_commit;
  logic                rd_commit;

  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   byte_addr [NB];
  logic [WORD_W-1:0]   rd_word;

  // State register and captured request; everything except the memory array resets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wren_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      done_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= commit;
      if (accept) begin
        wren_reg  <= wren;
        addr_reg  <= address;
        wdata_reg <= wdata;
        be_reg    <= byte_en;
      end
      if (rd_commit) begin
        rdata_reg <= rd_word;
      end
    end
  end

  // Next-state logic: the counter is loaded with LATENCY on acceptance and the
  // access commits on the edge where it would step from 1 to 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = BUSY;
          cnt_next   = LAT;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    ready  = (state_reg == IDLE);
    accept = ready && req;
    commit = (state_reg == BUSY) && (cnt_reg == 4'd1);
  end

`ifdef DRAM_ALIGN_CHECK_EN
  logic err_reg;

  assign misaligned = (addr_reg % ADDR_W'(NB)) != '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= commit && misaligned;
    end
  end

  assign err = err_reg;
`else
  assign misaligned = 1'b0;
  assign err        = 1'b0;
`endif

  assign wr_commit = commit && wren_reg && !misaligned;
  assign rd_commit = commit && !wren_reg && !misaligned;
  assign done      = done_reg;
  assign rdata     = rdata_reg;

  // Each byte lane addresses its own location; the sum wraps at the top of memory.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign byte_addr[gi]          = addr_reg + ADDR_W'(gi);
      assign rd_word[gi*8 +: 8]     = mem[byte_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wr_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (be_reg[i]) begin
          mem[byte_addr[i]] <= wdata_reg[i*8 +: 8];
        end
      end
    end
  end

endmodule
